int2flt: RTL

Synthesizable 16-bit two's-complement integer to IEEE-754 half-precision (fp16) converter; the inverse of the team's fp16-to-int converter. Triggered by the test bench start/done handshake, it reads the integer from data memory, normalizes it iteratively (one shift per cycle), rounds, and writes the fp16 result back to data memory. It is the hardware reference for the int-to-float program and drives the shared byte-wide data_mem port.

---
 rtl/int2flt_pkg.sv | 25 ++
 rtl/fp16_round.sv | 33 +++
 rtl/int2flt.sv | 131 +++++++++++++
 3 files changed

// File: rtl/int2flt_pkg.sv
// Shared types and fp16 format constants for the int2flt converter.
package int2flt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        NORM,
        ROUND,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    localparam int FP16_EXP_W  = 5;
    localparam int FP16_MANT_W = 10;
    localparam int FP16_BIAS   = 15;
    localparam int MAX_EXP     = FP16_BIAS + 15;

    // Absolute value of a 16-bit two's-complement word; -32768 wraps to 0x8000.
    function automatic logic [15:0] magnitude(input logic [15:0] value);
        return value[15] ? (~value + 16'd1) : value;
    endfunction

endpackage

// File: rtl/fp16_round.sv
// Combinational fp16 packer with optional rounding.
// ROUND_NEAREST_EN defined: round to nearest, ties to even. Undefined: truncate.
module fp16_round
    import int2flt_pkg::*;
(
    input  logic                   sign,
    input  logic [FP16_EXP_W-1:0]  exp,
    input  logic [FP16_MANT_W-1:0] mant,
    input  logic                   guard,
    input  logic                   sticky,
    output logic [15:0]            result
);

`ifdef ROUND_NEAREST_EN
    logic                 round_up;
    logic [FP16_MANT_W:0] mant_sum;

    // A mantissa carry-out leaves mant_sum's low bits at zero and bumps the exponent.
    always_comb begin
        round_up = guard && (sticky || mant[0]);
        mant_sum = {1'b0, mant} + {{FP16_MANT_W{1'b0}}, round_up};
        result   = {sign,
                    exp + {{(FP16_EXP_W-1){1'b0}}, mant_sum[FP16_MANT_W]},
                    mant_sum[FP16_MANT_W-1:0]};
    end
`else
    logic unused_round_bits;

    assign unused_round_bits = guard ^ sticky;
    assign result            = {sign, exp, mant};
`endif

endmodule

// File: rtl/int2flt.sv
// 16-bit integer to fp16 converter driving the shared byte-wide data memory port.
// Rounding mode selected by ROUND_NEAREST_EN (see fp16_round).
module int2flt
    import int2flt_pkg::*;
#(
    parameter logic [7:0] SRC_ADDR = 8'd0,
    parameter logic [7:0] DST_ADDR = 8'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic       busy,
    output logic [7:0] dm_addr,
    output logic       dm_rd_en,
    output logic       dm_wr_en,
    output logic [7:0] dm_wdata,
    input  logic [7:0] dm_rdata
);

    state_t      state;
    state_t      state_next;
    logic        start_q;
    logic        trigger;
    logic [7:0]  lo_byte;
    logic        sign;
    logic [15:0] mag;
    logic [3:0]  shift_ctr;
    logic [15:0] result;
    logic [15:0] rounded;
    logic [FP16_EXP_W-1:0] exp_val;

    assign trigger = start_q && !start;
    assign exp_val = FP16_EXP_W'(MAX_EXP) - {1'b0, shift_ctr};

    fp16_round u_round (
        .sign   (sign),
        .exp    (exp_val),
        .mant   (mag[14:5]),
        .guard  (mag[4]),
        .sticky (|mag[3:0]),
        .result (rounded)
    );

    // A zero operand spends one NORM cycle, then skips rounding with a cleared result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            lo_byte   <= 8'd0;
            sign      <= 1'b0;
            mag       <= 16'd0;
            shift_ctr <= 4'd0;
            result    <= 16'd0;
        end else begin
            state   <= state_next;
            start_q <= start;
            case (state)
                RD_LO: lo_byte <= dm_rdata;
                RD_HI: begin
                    sign      <= dm_rdata[7];
                    mag       <= magnitude({dm_rdata, lo_byte});
                    shift_ctr <= 4'd0;
                end
                NORM: begin
                    if (mag == 16'd0) begin
                        result <= 16'd0;
                    end else if (!mag[15]) begin
                        mag       <= mag << 1;
                        shift_ctr <= shift_ctr + 4'd1;
                    end
                end
                ROUND:   result <= rounded;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        busy       = 1'b1;
        dm_addr    = 8'd0;
        dm_rd_en   = 1'b0;
        dm_wr_en   = 1'b0;
        dm_wdata   = 8'd0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (trigger) state_next = RD_LO;
            end
            RD_LO: begin
                dm_addr    = SRC_ADDR;
                dm_rd_en   = 1'b1;
                state_next = RD_HI;
            end
            RD_HI: begin
                dm_addr    = SRC_ADDR + 8'd1;
                dm_rd_en   = 1'b1;
                state_next = NORM;
            end
            NORM: begin
                if (mag == 16'd0)  state_next = WR_LO;
                else if (mag[15])  state_next = ROUND;
            end
            ROUND: state_next = WR_LO;
            WR_LO: begin
                dm_addr    = DST_ADDR;
                dm_wr_en   = 1'b1;
                dm_wdata   = result[7:0];
                state_next = WR_HI;
            end
            WR_HI: begin
                dm_addr    = DST_ADDR + 8'd1;
                dm_wr_en   = 1'b1;
                dm_wdata   = result[15:8];
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                busy       = 1'b0;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule
